// File: rtl/nds_sync_p2p_arb_pkg.sv
// Shared definitions for the nds_sync_p2p_arb pulse+data CDC sequencer.
//   state_t / S_*  : FSM state encoding (IDLE=0, LAUNCH=1, WAIT_ACK=2, GAP=3)
//   TMO_CNT_W      : width of the optional WAIT_ACK timeout counter
//   gap_cnt_w()    : width of the post-ack gap down-counter for a given GAP
package nds_sync_p2p_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE     = 2'd0;
    localparam state_t S_LAUNCH   = 2'd1;
    localparam state_t S_WAIT_ACK = 2'd2;
    localparam state_t S_GAP      = 2'd3;

    localparam int TMO_CNT_W = 16;

    // The counter holds GAP-1 at most, so clog2(GAP) bits suffice; keep at
    // least one bit so GAP of 0 or 1 still yields a legal vector.
    function automatic int gap_cnt_w(input int gap);
        if (gap > 1) return $clog2(gap);
        return 1;
    endfunction

endpackage

// File: rtl/nds_sync_p2p_arb_if.sv
// Bundle of requester, synchronizer and status signals around nds_sync_p2p_arb.
//   master : arbiter side (drives grants, tx_* launch signals, busy, timeout_err)
//   slave  : environment side (requesters, far-side ack, error clear)
// Signals:
//   req_valid[NREQ], req_data[NREQ*DATA_BIT], req_grant[NREQ],
//   tx_pulse, tx_data[DATA_BIT], tx_id[ID_W], ack_pulse, busy, timeout_err, err_clr
interface nds_sync_p2p_arb_if
    import nds_sync_p2p_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DATA_BIT = 32,
    parameter int ID_W     = 2
);
    logic [NREQ-1:0]          req_valid;
    logic [NREQ*DATA_BIT-1:0] req_data;
    logic [NREQ-1:0]          req_grant;
    logic                     tx_pulse;
    logic [DATA_BIT-1:0]      tx_data;
    logic [ID_W-1:0]          tx_id;
    logic                     ack_pulse;
    logic                     busy;
    logic                     timeout_err;
    logic                     err_clr;

    modport master (
        input  req_valid, req_data, ack_pulse, err_clr,
        output req_grant, tx_pulse, tx_data, tx_id, busy, timeout_err
    );

    modport slave (
        output req_valid, req_data, ack_pulse, err_clr,
        input  req_grant, tx_pulse, tx_data, tx_id, busy, timeout_err
    );

endinterface

// File: rtl/nds_sync_p2p_arb_rr.sv
// nds_rr_arb: combinational round-robin picker.
// Picks the first set bit of req at or after rr_ptr, wrapping to the lowest
// set bit when nothing at or above rr_ptr is requesting.
// Ports:
//   req    in  NREQ   request vector
//   rr_ptr in  ID_W   search start index (must be < NREQ)
//   grant  out NREQ   one-hot winner (all zero when req is zero)
//   idx    out ID_W   winner index (0 when req is zero)
//   any    out 1      at least one request present
module nds_rr_arb
    import nds_sync_p2p_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    logic            hi_found;
    logic [ID_W-1:0] hi_idx;
    logic [ID_W-1:0] lo_idx;

    // Scanning downwards lets the last hit be the lowest index: lo_idx is the
    // lowest requester overall, hi_idx the lowest one at or above rr_ptr.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        any      = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                any    = 1'b1;
                lo_idx = ID_W'(i);
                if (ID_W'(i) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end
            end
        end
        idx   = hi_found ? hi_idx : lo_idx;
        grant = any ? ({{(NREQ-1){1'b0}}, 1'b1} << idx) : '0;
    end

endmodule

// File: rtl/nds_sync_p2p_arb.sv
// nds_sync_p2p_arb: b_clk-side arbiter/sequencer for one shared pulse+data
// CDC channel. Grants one requester round-robin, launches a 1-cycle tx_pulse
// with tx_data/tx_id held stable, waits for the synced-back ack_pulse, then
// idles GAP cycles so the synchronizer never sees overlapping pulses.
// Optional feature macro: NDS_SYNC_P2P_ARB_TIMEOUT_EN (WAIT_ACK timeout with
// sticky timeout_err, cleared by err_clr). Without it timeout_err is 0.
// Ports:
//   b_clk      in  clock
//   b_reset_n  in  asynchronous active-low reset
//   bus        nds_sync_p2p_arb_if.master (requests, grants, tx_*, ack, status)
module nds_sync_p2p_arb
    import nds_sync_p2p_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DATA_BIT = 32,
    parameter int ID_W     = 2,
    parameter int GAP      = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic                   b_clk,
    input  logic                   b_reset_n,
    nds_sync_p2p_arb_if.master     bus
);

    localparam int                  GAP_CW   = gap_cnt_w(GAP);
    localparam logic [GAP_CW-1:0]   GAP_LD   = GAP_CW'((GAP > 0) ? GAP - 1 : 0);
    localparam state_t              POST_ACK = (GAP > 0) ? S_GAP : S_IDLE;

    state_t              state;
    state_t              state_nxt;
    logic [NREQ-1:0]     pick_grant;
    logic [ID_W-1:0]     pick_idx;
    logic                pick_any;
    logic                grant_fire;
    logic [ID_W-1:0]     rr_ptr;
    logic [GAP_CW-1:0]   gap_cnt;
    logic                tx_pulse_q;
    logic [DATA_BIT-1:0] tx_data_q;
    logic [ID_W-1:0]     tx_id_q;
    logic                timeout_hit;

    nds_rr_arb #(.NREQ(NREQ), .ID_W(ID_W)) u_rr (
        .req    (bus.req_valid),
        .rr_ptr (rr_ptr),
        .grant  (pick_grant),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign grant_fire = (state == S_IDLE) && pick_any;

`ifdef NDS_SYNC_P2P_ARB_TIMEOUT_EN
    logic [TMO_CNT_W-1:0] wait_cnt;
    logic                 timeout_err_q;

    // wait_cnt counts completed WAIT_ACK cycles; +1 includes the current one,
    // so the timeout fires at the end of the TIMEOUT-th cycle without ack.
    assign timeout_hit = (state == S_WAIT_ACK) && !bus.ack_pulse &&
                         (wait_cnt + 1'b1 == TMO_CNT_W'(TIMEOUT));

    always_ff @(posedge b_clk or negedge b_reset_n) begin
        if (!b_reset_n) begin
            wait_cnt      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (state == S_LAUNCH)
                wait_cnt <= '0;
            else if (state == S_WAIT_ACK)
                wait_cnt <= wait_cnt + 1'b1;
            // A new timeout takes priority over a simultaneous clear.
            if (timeout_hit)
                timeout_err_q <= 1'b1;
            else if (bus.err_clr)
                timeout_err_q <= 1'b0;
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    logic unused_cfg;
    assign unused_cfg      = ^{bus.err_clr, TIMEOUT[0]};
    assign timeout_hit     = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge b_clk or negedge b_reset_n) begin
        if (!b_reset_n) state <= S_IDLE;
        else            state <= state_nxt;
    end

    // FSM next state; ack outside LAUNCH/WAIT_ACK is ignored
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (pick_any) state_nxt = S_LAUNCH;
            S_LAUNCH:   state_nxt = bus.ack_pulse ? POST_ACK : S_WAIT_ACK;
            S_WAIT_ACK: if (bus.ack_pulse || timeout_hit) state_nxt = POST_ACK;
            S_GAP:      if (gap_cnt == '0) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs; grants only leave IDLE, so one transfer is in flight at most
    always_comb begin
        bus.req_grant = (state == S_IDLE) ? pick_grant : '0;
        bus.busy      = (state != S_IDLE);
    end

    // Payload, id and round-robin pointer move only on a grant
    always_ff @(posedge b_clk or negedge b_reset_n) begin
        if (!b_reset_n) begin
            tx_data_q  <= '0;
            tx_id_q    <= '0;
            rr_ptr     <= '0;
            tx_pulse_q <= 1'b0;
        end else begin
            tx_pulse_q <= grant_fire;
            if (grant_fire) begin
                tx_data_q <= bus.req_data[pick_idx*DATA_BIT +: DATA_BIT];
                tx_id_q   <= pick_idx;
                rr_ptr    <= (pick_idx == ID_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
            end
        end
    end

    // Gap down-counter: loaded on entry to GAP, leaves GAP when it hits 0
    always_ff @(posedge b_clk or negedge b_reset_n) begin
        if (!b_reset_n)
            gap_cnt <= '0;
        else if (state != S_GAP && state_nxt == S_GAP)
            gap_cnt <= GAP_LD;
        else if (state == S_GAP && gap_cnt != '0)
            gap_cnt <= gap_cnt - 1'b1;
    end

    assign bus.tx_pulse = tx_pulse_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_id    = tx_id_q;

endmodule

// File: tb/tb_nds_sync_p2p_arb.sv
// Directed self-checking bench for nds_sync_p2p_arb (NREQ=4, GAP=2, TIMEOUT=8).
// Inputs change 2 ns after the rising edge; outputs are sampled 1 ns later.
// Honours NDS_SYNC_P2P_ARB_TIMEOUT_EN for the timeout scenario.
module tb_nds_sync_p2p_arb;

    localparam int NREQ     = 4;
    localparam int DATA_BIT = 32;
    localparam int ID_W     = 2;
    localparam int GAP      = 2;
    localparam int TIMEOUT  = 8;

    logic b_clk     = 1'b0;
    logic b_reset_n = 1'b0;
    int   checks    = 0;
    int   errors    = 0;

    always #5 b_clk = ~b_clk;

    nds_sync_p2p_arb_if #(.NREQ(NREQ), .DATA_BIT(DATA_BIT), .ID_W(ID_W)) bus ();

    nds_sync_p2p_arb #(
        .NREQ(NREQ), .DATA_BIT(DATA_BIT), .ID_W(ID_W), .GAP(GAP), .TIMEOUT(TIMEOUT)
    ) dut (
        .b_clk     (b_clk),
        .b_reset_n (b_reset_n),
        .bus       (bus)
    );

    task automatic step();
        @(posedge b_clk);
        #2;
    endtask

    task automatic set_data(input int slot, input logic [DATA_BIT-1:0] d);
        bus.req_data[slot*DATA_BIT +: DATA_BIT] = d;
    endtask

    task automatic test_reset();
        b_reset_n = 1'b0;
        #1;
        checks++; if (bus.tx_pulse !== 1'b0) begin errors++; $display("FAIL reset_tx_pulse got %b want 0", bus.tx_pulse); end
        checks++; if (bus.tx_data !== 32'h0) begin errors++; $display("FAIL reset_tx_data got %h want 0", bus.tx_data); end
        checks++; if (bus.tx_id !== 2'd0) begin errors++; $display("FAIL reset_tx_id got %0d want 0", bus.tx_id); end
        checks++; if (bus.req_grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", bus.req_grant); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %b want 0", bus.timeout_err); end
        step();
        step();
        b_reset_n = 1'b1;
        step();
    endtask

    // All four request continuously; ack is given 3 cycles after each grant,
    // so grant-to-grant = IDLE + LAUNCH + 2 WAIT_ACK + 2 GAP = 6 cycles.
    task automatic test_round_robin();
        int          exp_order [5] = '{0, 1, 2, 3, 0};
        logic [3:0]  one = 4'b0001;
        int          last = -100;
        int          ngr  = 0;
        int          lidx = 0;
        for (int i = 0; i < NREQ; i++) set_data(i, 32'h1111_0000 | i);
        bus.req_valid = 4'b1111;
        for (int cyc = 0; cyc < 60; cyc++) begin
            bus.ack_pulse = (ngr > 0) && (cyc == last + 3);
            if (ngr == 5 && cyc > last) bus.req_valid = 4'b0000;
            #1;
            if (ngr > 0 && cyc == last + 1) begin
                checks++; if (bus.tx_pulse !== 1'b1) begin errors++; $display("FAIL rr_tx_pulse grant%0d got %b want 1", ngr - 1, bus.tx_pulse); end
                checks++; if (bus.tx_data !== (32'h1111_0000 | lidx)) begin errors++; $display("FAIL rr_tx_data grant%0d got %h want %h", ngr - 1, bus.tx_data, 32'h1111_0000 | lidx); end
                checks++; if (bus.tx_id !== ID_W'(lidx)) begin errors++; $display("FAIL rr_tx_id grant%0d got %0d want %0d", ngr - 1, bus.tx_id, lidx); end
            end
            if (bus.req_grant !== 4'b0000) begin
                if (ngr < 5) begin
                    checks++; if (bus.req_grant !== (one << exp_order[ngr])) begin errors++; $display("FAIL rr_order grant%0d got %b want %b", ngr, bus.req_grant, one << exp_order[ngr]); end
                    if (ngr > 0) begin
                        checks++; if (cyc - last !== 6) begin errors++; $display("FAIL rr_spacing grant%0d got %0d want 6", ngr, cyc - last); end
                    end
                    lidx = exp_order[ngr];
                end
                last = cyc;
                ngr++;
            end
            if (ngr == 5 && cyc == last + 6) begin
                checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rr_final_idle busy got %b want 0", bus.busy); end
                break;
            end
            step();
        end
        bus.ack_pulse = 1'b0;
        bus.req_valid = 4'b0000;
        checks++; if (ngr !== 5) begin errors++; $display("FAIL rr_grant_count got %0d want 5", ngr); end
        step();
    endtask

    task automatic test_single();
        set_data(1, 32'hA5A5_0001);
        bus.req_valid = 4'b0010;
        #1;
        checks++; if (bus.req_grant !== 4'b0010) begin errors++; $display("FAIL single_grant got %b want 0010", bus.req_grant); end
        step();
        bus.req_valid = 4'b0000;
        #1;
        checks++; if (bus.tx_pulse !== 1'b1) begin errors++; $display("FAIL single_tx_pulse got %b want 1", bus.tx_pulse); end
        checks++; if (bus.tx_data !== 32'hA5A5_0001) begin errors++; $display("FAIL single_tx_data got %h want a5a50001", bus.tx_data); end
        checks++; if (bus.tx_id !== 2'd1) begin errors++; $display("FAIL single_tx_id got %0d want 1", bus.tx_id); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_launch got %b want 1", bus.busy); end
        step();
        bus.ack_pulse = 1'b1;
        #1;
        checks++; if (bus.tx_pulse !== 1'b0) begin errors++; $display("FAIL single_pulse_width got %b want 0", bus.tx_pulse); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_wait got %b want 1", bus.busy); end
        step();
        bus.ack_pulse = 1'b0;
        step();
        #1;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_gap2 got %b want 1", bus.busy); end
        step();
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle_after_gap got %b want 0", bus.busy); end
        step();
    endtask

    task automatic test_idle_ack();
        bus.ack_pulse = 1'b1;
        #1;
        checks++; if (bus.req_grant !== 4'b0000) begin errors++; $display("FAIL idle_ack_grant got %b want 0000", bus.req_grant); end
        step();
        bus.ack_pulse = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_ack_busy got %b want 0", bus.busy); end
        checks++; if (bus.tx_data !== 32'hA5A5_0001) begin errors++; $display("FAIL idle_hold_tx_data got %h want a5a50001", bus.tx_data); end
        step();
    endtask

    // rr_ptr is 2 here, so a lone request from 0 exercises the wrap-around.
    task automatic test_ack_on_launch();
        set_data(0, 32'h0000_C0DE);
        bus.req_valid = 4'b0001;
        #1;
        checks++; if (bus.req_grant !== 4'b0001) begin errors++; $display("FAIL launch_ack_wrap_grant got %b want 0001", bus.req_grant); end
        step();
        bus.req_valid = 4'b0000;
        bus.ack_pulse = 1'b1;
        #1;
        checks++; if (bus.tx_pulse !== 1'b1) begin errors++; $display("FAIL launch_ack_pulse got %b want 1", bus.tx_pulse); end
        step();
        bus.ack_pulse = 1'b0;
        step();
        bus.req_valid = 4'b0001;
        #1;
        checks++; if (bus.req_grant !== 4'b0000) begin errors++; $display("FAIL launch_ack_no_grant_in_gap got %b want 0000", bus.req_grant); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL launch_ack_busy_gap got %b want 1", bus.busy); end
        step();
        #1;
        checks++; if (bus.req_grant !== 4'b0001) begin errors++; $display("FAIL launch_ack_regrant got %b want 0001", bus.req_grant); end
        step();
        bus.req_valid = 4'b0000;
        bus.ack_pulse = 1'b1;
        step();
        bus.ack_pulse = 1'b0;
        step();
        step();
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL launch_ack_idle got %b want 0", bus.busy); end
        step();
    endtask

    task automatic test_reset_mid();
        set_data(2, 32'hDEAD_BEEF);
        bus.req_valid = 4'b0100;
        #1;
        checks++; if (bus.req_grant !== 4'b0100) begin errors++; $display("FAIL rstmid_grant got %b want 0100", bus.req_grant); end
        step();
        bus.req_valid = 4'b0000;
        step();
        #1;
        checks++; if (bus.tx_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rstmid_tx_data got %h want deadbeef", bus.tx_data); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_wait got %b want 1", bus.busy); end
        b_reset_n = 1'b0;
        #1;
        checks++; if (bus.tx_data !== 32'h0) begin errors++; $display("FAIL rstmid_tx_data_cleared got %h want 0", bus.tx_data); end
        checks++; if (bus.tx_id !== 2'd0) begin errors++; $display("FAIL rstmid_tx_id got %0d want 0", bus.tx_id); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
        step();
        b_reset_n = 1'b1;
        bus.ack_pulse = 1'b1;
        step();
        bus.ack_pulse = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_late_ack busy got %b want 0", bus.busy); end
        checks++; if (bus.tx_pulse !== 1'b0) begin errors++; $display("FAIL rstmid_late_ack pulse got %b want 0", bus.tx_pulse); end
        step();
    endtask

    // rr_ptr is 0 after reset; the only requester is 3.
    task automatic test_timeout();
        bit exp_busy;
        bit exp_err;
        set_data(3, 32'h7777_0003);
        bus.req_valid = 4'b1000;
        #1;
        checks++; if (bus.req_grant !== 4'b1000) begin errors++; $display("FAIL tmo_grant got %b want 1000", bus.req_grant); end
        step();
        bus.req_valid = 4'b0000;
        step();
        for (int k = 0; k <= 10; k++) begin
`ifdef NDS_SYNC_P2P_ARB_TIMEOUT_EN
            exp_busy = (k <= 9);
            exp_err  = (k >= 8);
`else
            exp_busy = 1'b1;
            exp_err  = 1'b0;
`endif
            #1;
            checks++; if (bus.busy !== exp_busy) begin errors++; $display("FAIL tmo_busy k=%0d got %b want %b", k, bus.busy, exp_busy); end
            checks++; if (bus.timeout_err !== exp_err) begin errors++; $display("FAIL tmo_err k=%0d got %b want %b", k, bus.timeout_err, exp_err); end
            step();
        end
        checks++; if (bus.tx_data !== 32'h7777_0003) begin errors++; $display("FAIL tmo_tx_data got %h want 77770003", bus.tx_data); end
`ifdef NDS_SYNC_P2P_ARB_TIMEOUT_EN
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        #1;
        checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_err_clr got %b want 0", bus.timeout_err); end
`else
        bus.ack_pulse = 1'b1;
        step();
        bus.ack_pulse = 1'b0;
        step();
        step();
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL tmo_ack_release got %b want 0", bus.busy); end
`endif
        step();
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.ack_pulse = 1'b0;
        bus.err_clr   = 1'b0;
        test_reset();
        test_round_robin();
        test_single();
        test_idle_ack();
        test_ack_on_launch();
        test_reset_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
